slave_fifo_master: RTL and testbench

Parametrised bidirectional master for the FX2 slave-FIFO bus, replacing the single-direction read/write sequencer. Arbitrates between the OUT endpoint (host→FPGA, drained into a local rx stream) and the IN endpoint (FPGA→host, filled from a local show-ahead tx FIFO) with round-robin fairness, a per-turn burst limit, automatic short-packet commit (PKTEND) on idle timeout or flush, and backpressure on both local sides. Sits between the FX2 pins and the board's data FIFOs.

---
 rtl/slave_fifo_master.sv | 177 +++++++++++++++++
 tb/tb_slave_fifo_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_fifo_master.sv
// Bidirectional FX2 slave-FIFO master: round-robin OUT->rx / tx->IN transfers
// with per-turn burst limit and automatic short-packet commit via PKTEND.
module slave_fifo_master #(
    parameter int unsigned DW           = 16,
    parameter logic [1:0]  RD_ADDR      = 2'b00,
    parameter logic [1:0]  WR_ADDR      = 2'b10,
    parameter int unsigned BURST        = 64,
    parameter int unsigned PKT_WORDS    = 256,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLAG_EMPTY,
    input  logic          FLAG_FULL,
    inout  wire  [DW-1:0] FD,
    output logic          SLOE,
    output logic          SLRD,
    output logic          SLWR,
    output logic [1:0]    FIFOADR,
    output logic          PKTEND,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic          flush,
    output logic [2:0]    state_monitor
);

    localparam int unsigned BW = $clog2(BURST + 1);
    localparam int unsigned PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int unsigned TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
    localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_WORDS - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_SETUP   = 3'd1,
        RD_SAMPLE  = 3'd2,
        RD_RELEASE = 3'd3,
        WR_SETUP   = 3'd4,
        WR_STROBE  = 3'd5,
        WR_RELEASE = 3'd6,
        PKTEND_ST  = 3'd7
    } state_t;

    state_t        state;
    logic [DW-1:0] fd;
    logic          fd_oe;
    logic [BW-1:0] burst_cnt;
    logic [PW-1:0] pkt_cnt;
    logic [TW-1:0] timer;
    logic          flush_pend;
    logic          last_rd;

    logic timeout_hit, pe_req, rd_req, wr_req, rd_go, wr_go, wr_word;

    assign timeout_hit = (IDLE_TIMEOUT != 0) && (timer == TIMER_MAX);
    assign pe_req      = (pkt_cnt != '0) && (timeout_hit || flush_pend);
    assign rd_req      = !FLAG_EMPTY && rx_ready;
    assign wr_req      = tx_valid && !FLAG_FULL;
    assign rd_go       = rd_req && (burst_cnt < BURST_MAX);
    assign wr_go       = wr_req && (burst_cnt < BURST_MAX);
    assign wr_word     = (state == WR_STROBE) && wr_go;

    assign FD            = fd_oe ? fd : 'z;
    assign state_monitor = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            SLOE      <= 1'b0;
            SLRD      <= 1'b0;
            SLWR      <= 1'b0;
            PKTEND    <= 1'b0;
            FIFOADR   <= RD_ADDR;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            fd        <= '0;
            fd_oe     <= 1'b0;
            burst_cnt <= '0;
            pkt_cnt   <= '0;
            last_rd   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    // Commit beats both directions; on contention take the one not served last.
                    if (pe_req) begin
                        FIFOADR <= WR_ADDR;
                        PKTEND  <= 1'b1;
                        state   <= PKTEND_ST;
                    end else if (rd_req && (!wr_req || !last_rd)) begin
                        FIFOADR <= RD_ADDR;
                        SLOE    <= 1'b1;
                        last_rd <= 1'b1;
                        state   <= RD_SETUP;
                    end else if (wr_req) begin
                        FIFOADR <= WR_ADDR;
                        fd_oe   <= 1'b1;
                        last_rd <= 1'b0;
                        state   <= WR_SETUP;
                    end
                end
                RD_SETUP: state <= RD_SAMPLE;
                RD_SAMPLE: begin
                    if (rd_go) begin
                        rx_data   <= FD;
                        rx_valid  <= 1'b1;
                        SLRD      <= 1'b1;
                        burst_cnt <= burst_cnt + 1'b1;
                        state     <= RD_RELEASE;
                    end else begin
                        SLOE      <= 1'b0;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                RD_RELEASE: begin
                    SLRD     <= 1'b0;
                    rx_valid <= 1'b0;
                    state    <= RD_SAMPLE;
                end
                WR_SETUP: state <= WR_STROBE;
                WR_STROBE: begin
                    if (wr_go) begin
                        fd        <= tx_data;
                        tx_ready  <= 1'b1;
                        SLWR      <= 1'b1;
                        burst_cnt <= burst_cnt + 1'b1;
                        pkt_cnt   <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
                        state     <= WR_RELEASE;
                    end else begin
                        fd_oe     <= 1'b0;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                WR_RELEASE: begin
                    SLWR     <= 1'b0;
                    tx_ready <= 1'b0;
                    state    <= WR_STROBE;
                end
                PKTEND_ST: begin
                    PKTEND    <= 1'b0;
                    pkt_cnt   <= '0;
                    burst_cnt <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Idle timer restarts on every IN word and saturates at the timeout value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            timer <= '0;
        else if (state == PKTEND_ST || wr_word)
            timer <= '0;
        else if (pkt_cnt != '0 && timer < TIMER_MAX)
            timer <= timer + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            flush_pend <= 1'b0;
        else if (flush)
            flush_pend <= 1'b1;
        else if (state == PKTEND_ST || (state == IDLE && pkt_cnt == '0))
            flush_pend <= 1'b0;
    end

endmodule

// File: tb/tb_slave_fifo_master.sv
// Directed/randomised bench for slave_fifo_master: FX2 endpoint and local FIFO
// models, stream scoreboards and packet-commit bookkeeping.
module tb_slave_fifo_master;

    localparam int         DW    = 16;
    localparam logic [1:0] RD_A  = 2'b00;
    localparam logic [1:0] WR_A  = 2'b10;
    localparam int         PKT   = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FLAG_EMPTY = 1'b1;
    logic          FLAG_FULL = 1'b0;
    wire  [DW-1:0] FD;
    logic          SLOE, SLRD, SLWR, PKTEND, rx_valid, tx_ready;
    logic [1:0]    FIFOADR;
    logic [DW-1:0] rx_data;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    state_monitor;

    logic [DW-1:0] fx_out = '0;
    logic          probe_en = 1'b0;
    logic [DW-1:0] probe_val = '0;

    // Host side of the OUT endpoint drives FD while SLOE selects it; probe tests for hi-Z.
    assign FD = (SLOE && FIFOADR == RD_A) ? fx_out : (probe_en ? probe_val : 'z);

    slave_fifo_master #(
        .DW(DW), .RD_ADDR(RD_A), .WR_ADDR(WR_A),
        .BURST(4), .PKT_WORDS(PKT), .IDLE_TIMEOUT(16)
    ) dut (
        .CLK(CLK), .RST(RST), .FLAG_EMPTY(FLAG_EMPTY), .FLAG_FULL(FLAG_FULL),
        .FD(FD), .SLOE(SLOE), .SLRD(SLRD), .SLWR(SLWR), .FIFOADR(FIFOADR),
        .PKTEND(PKTEND), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .flush(flush), .state_monitor(state_monitor)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] out_q[$], tx_q[$], rx_got[$], in_got[$], exp_rx[$], exp_in[$];
    bit            dir_log[$];
    int            slrd_cyc[$];
    int cyc = 0, n_slrd = 0, n_pe = 0, proto_err = 0, in_space = 1000;
    int vectors = 0, miscompares = 0;
    int pe_exp = 0, wr_pend = 0;

    function automatic void refresh();
        FLAG_EMPTY = (out_q.size() == 0);
        fx_out     = FLAG_EMPTY ? '0 : out_q[0];
        tx_valid   = (tx_q.size() != 0);
        tx_data    = tx_valid ? tx_q[0] : '0;
        FLAG_FULL  = (in_space == 0);
    endfunction

    // Endpoint/FIFO model: consumes strobes seen during the cycle just ended.
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (SLRD) begin
                n_slrd++;
                slrd_cyc.push_back(cyc);
                dir_log.push_back(1'b0);
                if (out_q.size() > 0) void'(out_q.pop_front());
            end
            if (rx_valid) rx_got.push_back(rx_data);
            if (SLWR) begin
                in_got.push_back(FD);
                dir_log.push_back(1'b1);
                if (in_space > 0) in_space--;
            end
            if (tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_ready !== SLWR) proto_err++;
            if (PKTEND) begin
                n_pe++;
                if (FIFOADR !== WR_A) proto_err++;
            end
            if (SLOE && (SLWR || (state_monitor >= 3'd4 && state_monitor <= 3'd6))) proto_err++;
        end
        refresh();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic push_rd(input int n);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            out_q.push_back(w);
            exp_rx.push_back(w);
        end
        refresh();
    endtask

    task automatic push_wr(input int n);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = DW'($urandom_range(1, 65535));
            tx_q.push_back(w);
            exp_in.push_back(w);
        end
        refresh();
    endtask

    // Long quiet period: any partial packet must have been committed by the timeout.
    task automatic settle();
        tick(40);
        if (wr_pend % PKT != 0) pe_exp++;
        wr_pend = 0;
    endtask

    task automatic cmp_streams(input string tag);
        check({tag, "_rx_len"}, 32'(rx_got.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
            check({tag, "_rx_word"}, 32'(rx_got[i]), 32'(exp_rx[i]));
        check({tag, "_in_len"}, 32'(in_got.size()), 32'(exp_in.size()));
        for (int i = 0; i < exp_in.size() && i < in_got.size(); i++)
            check({tag, "_in_word"}, 32'(in_got[i]), 32'(exp_in[i]));
        check({tag, "_protocol"}, 32'(proto_err), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sloe"}, 32'(SLOE), 32'd0);
        check({tag, "_slrd"}, 32'(SLRD), 32'd0);
        check({tag, "_slwr"}, 32'(SLWR), 32'd0);
        check({tag, "_pktend"}, 32'(PKTEND), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
        check({tag, "_fifoadr"}, 32'(FIFOADR), 32'(RD_A));
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_state"}, 32'(state_monitor), 32'd0);
        probe_en  = 1'b1;
        probe_val = '0;
        #1;
        check({tag, "_fd_hiz"}, 32'(FD), 32'd0);
        probe_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, s0, k0, base;
        bit found;
        refresh();
        tick(2);
        check_quiet("reset");

        @(negedge CLK);
        RST = 1'b0;
        rx_ready = 1'b1;
        #1;

        // Both directions pending from reset: R4 W4 R4 W4 R4 W4.
        push_rd(12);
        push_wr(12);
        wr_pend += 12;
        tick(120);
        check("arb_words", 32'(dir_log.size()), 32'd24);
        for (int i = 0; i < 24 && i < dir_log.size(); i++)
            check("arb_dir", 32'(dir_log[i]), 32'((i / 4) % 2));
        settle();
        check("arb_pktend", 32'(n_pe), 32'(pe_exp));
        cmp_streams("arb");

        // Read burst of 5 with first-word latency check.
        n0 = n_slrd;
        s0 = slrd_cyc.size();
        base = exp_rx.size();
        push_rd(5);
        tick(1);
        check("rd_sloe_up", 32'(SLOE), 32'd1);
        check("rd_setup_state", 32'(state_monitor), 32'd1);
        check("rd_fifoadr", 32'(FIFOADR), 32'(RD_A));
        tick(1);
        check("rd_sample_state", 32'(state_monitor), 32'd2);
        check("rd_no_early_slrd", 32'(SLRD), 32'd0);
        tick(1);
        check("rd_first_slrd", 32'(SLRD), 32'd1);
        check("rd_first_valid", 32'(rx_valid), 32'd1);
        check("rd_first_data", 32'(rx_data), 32'(exp_rx[base]));
        tick(1);
        check("rd_slrd_release", 32'(SLRD), 32'd0);
        tick(20);
        check("rd_count", 32'(n_slrd - n0), 32'd5);
        if (slrd_cyc.size() >= s0 + 4)
            check("rd_spacing", 32'(slrd_cyc[s0 + 3] - slrd_cyc[s0]), 32'd6);
        else
            check("rd_spacing_len", 32'(slrd_cyc.size() - s0), 32'd4);
        check("rd_sloe_down", 32'(SLOE), 32'd0);
        cmp_streams("rd_burst");

        // rx backpressure: data present, no reads while rx_ready low.
        rx_ready = 1'b0;
        n0 = n_slrd;
        push_rd(3);
        tick(20);
        check("rx_bp_no_slrd", 32'(n_slrd - n0), 32'd0);
        check("rx_bp_sloe", 32'(SLOE), 32'd0);
        rx_ready = 1'b1;
        tick(20);
        check("rx_bp_resume", 32'(n_slrd - n0), 32'd3);

        // IN endpoint fills after two words.
        in_space = 2;
        refresh();
        k0 = in_got.size();
        push_wr(5);
        tick(12);
        check("tx_bp_written", 32'(in_got.size() - k0), 32'd2);
        check("tx_bp_left", 32'(tx_q.size()), 32'd3);
        check("tx_bp_tx_ready", 32'(tx_ready), 32'd0);
        check("tx_bp_state", 32'(state_monitor), 32'd0);
        wr_pend += 2;
        settle();
        check("tx_bp_pktend", 32'(n_pe), 32'(pe_exp));
        in_space = 1000;
        refresh();
        wr_pend += 3;
        settle();
        check("tx_bp_drain_pktend", 32'(n_pe), 32'(pe_exp));
        cmp_streams("backpressure");

        // A full packet wraps silently; a short one is committed by the timeout.
        push_wr(PKT);
        wr_pend += PKT;
        settle();
        check("wrap_no_pktend", 32'(n_pe), 32'(pe_exp));
        push_wr(3);
        wr_pend += 3;
        settle();
        check("timeout_pktend", 32'(n_pe), 32'(pe_exp));

        // Flush of a 3-word partial packet, before the timeout could fire.
        push_wr(3);
        wr_pend += 3;
        tick(8);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(4);
        if (wr_pend % PKT != 0) pe_exp++;
        wr_pend = 0;
        check("flush_pktend", 32'(n_pe), 32'(pe_exp));
        settle();
        check("flush_no_repeat", 32'(n_pe), 32'(pe_exp));
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        settle();
        check("flush_empty", 32'(n_pe), 32'(pe_exp));
        push_wr(1);
        wr_pend += 1;
        tick(8);
        check("flush_pend_cleared", 32'(n_pe), 32'(pe_exp));
        settle();
        check("single_word_timeout", 32'(n_pe), 32'(pe_exp));
        cmp_streams("flush");

        // Asynchronous reset while a write word is being released.
        push_wr(6);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            tick(1);
            if (state_monitor == 3'd6) found = 1'b1;
        end
        check("reach_wr_release", 32'(found), 32'd1);
        #1 RST = 1'b1;
        #1;
        check_quiet("async_reset");
        tx_q.delete();
        wr_pend = 0;
        tick(2);
        @(negedge CLK);
        RST = 1'b0;
        tick(5);
        check("post_reset_state", 32'(state_monitor), 32'd0);
        check("post_reset_slwr", 32'(SLWR), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
